// File: rtl/fir_out_conditioner.sv
// rtl/fir_out_conditioner.sv - round/saturate, decimate and FIFO-buffer the FIR output stream
//
// Purpose: takes the signed FIR output, rounds half-up at a fixed binary point,
// saturates to OUT_W bits, keeps one sample in DECIM and buffers the survivors
// in a first-word-fall-through FIFO with a valid/ready output.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   in_valid     in_data carries a sample this cycle (no backpressure)
//   in_data      signed IN_W-bit filter output
//   out_valid    out_data holds the FIFO head
//   out_ready    consumer takes out_data this cycle
//   out_data     signed OUT_W-bit conditioned sample
//   fifo_level   number of occupied FIFO entries
//   ovf_sticky   a saturation has occurred since the last clear
//   drop_sticky  a kept sample was discarded because the FIFO was full
//   clr_flags    synchronous clear of both sticky flags (a same-cycle set wins)

module fir_out_conditioner #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int DECIM = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [IN_W-1:0]          in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     ovf_sticky,
  output logic                     drop_sticky,
  input  logic                     clr_flags
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int R_W    = IN_W + 1 - SHIFT;
  localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic signed [IN_W:0]    ROUND     = (IN_W+1)'(64'(1) << (SHIFT - 1));
  localparam logic signed [R_W-1:0]   SAT_MAX   = R_W'((2 ** (OUT_W - 1)) - 1);
  // Bitwise complement of 0..011..1 is 1..100..0, i.e. -2^(OUT_W-1).
  localparam logic signed [R_W-1:0]   SAT_MIN   = ~SAT_MAX;
  localparam logic [DCNT_W-1:0]       DCNT_LAST = DCNT_W'(DECIM - 1);
  localparam logic [DCNT_W-1:0]       DCNT_ONE  = DCNT_W'(1);
  localparam logic [PTR_W-1:0]        PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]          LVL_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]          LVL_FULL  = (PTR_W+1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Stage 1: round half-up. One extra bit of headroom keeps the +2^(SHIFT-1)
  // from wrapping on the most positive input.
  // ---------------------------------------------------------------------------
  logic signed [IN_W:0]  rsum;
  logic signed [IN_W:0]  rsum_sh;
  logic                  s1_valid;
  logic signed [R_W-1:0] s1_r;

  assign rsum    = $signed({in_data[IN_W-1], in_data}) + ROUND;
  assign rsum_sh = rsum >>> SHIFT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_r     <= R_W'(rsum_sh);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: saturate and decimate
  // ---------------------------------------------------------------------------
  logic              clamp_hi;
  logic              clamp_lo;
  logic [OUT_W-1:0]  sat_val;
  logic              keep;
  logic              ovf_set;
  logic [DCNT_W-1:0] dcnt;
  logic              s2_keep;
  logic [OUT_W-1:0]  s2_data;

  always_comb begin
    clamp_hi = (s1_r > SAT_MAX);
    clamp_lo = (s1_r < SAT_MIN);
    sat_val  = s1_r[OUT_W-1:0];
    if (clamp_hi) begin
      sat_val = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (clamp_lo) begin
      sat_val = {1'b1, {(OUT_W-1){1'b0}}};
    end
    keep    = s1_valid && (dcnt == '0);
    ovf_set = s1_valid && (clamp_hi || clamp_lo);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dcnt    <= '0;
      s2_keep <= 1'b0;
      s2_data <= '0;
    end else begin
      if (s1_valid) begin
        dcnt <= (dcnt == DCNT_LAST) ? '0 : dcnt + DCNT_ONE;
      end
      s2_keep <= keep;
      s2_data <= sat_val;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO: fall-through head, write accepted when not full or when the head
  // leaves in the same cycle.
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             rd;
  logic             wr;
  logic             drop_set;

  always_comb begin
    out_valid = (fifo_level != '0);
    rd        = out_valid && out_ready;
    wr        = s2_keep && ((fifo_level != LVL_FULL) || rd);
    drop_set  = s2_keep && !wr;
    out_data  = out_valid ? mem[rptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr] <= s2_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else begin
      if (wr) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd) begin
        rptr <= rptr + PTR_ONE;
      end
      case ({wr, rd})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_sticky  <= 1'b0;
      drop_sticky <= 1'b0;
    end else begin
      if (ovf_set) begin
        ovf_sticky <= 1'b1;
      end else if (clr_flags) begin
        ovf_sticky <= 1'b0;
      end
      if (drop_set) begin
        drop_sticky <= 1'b1;
      end else if (clr_flags) begin
        drop_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fir_out_conditioner.md
# fir_out_conditioner

Output stage placed directly downstream of the 5-tap CSD FIR filter. It takes the filter's 32-bit signed sample stream and rounds it to 16 bits with a programmable binary-point shift, saturating any out-of-range result. It then decimates the stream by a fixed factor and buffers the surviving samples in a small first-word-fall-through FIFO. Samples leave through a valid/ready handshake, and sticky overflow/drop flags are provided for status readback.

## Interface
- IN_W, 32, input sample width (signed).
- OUT_W, 16, output sample width (signed).
- SHIFT, 15, right-shift applied before saturation; must satisfy 1 ≤ SHIFT < IN_W.
- DECIM, 2, decimation factor; must be ≥ 1 (1 = pass every sample).
- DEPTH, 4, FIFO entries; must be a power of two ≥ 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  in_data is valid this cycle; there is no input backpressure.
- in_data  in  IN_W  signed filter output.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  OUT_W  signed conditioned sample.
- fifo_level  out  log2(DEPTH)+1  number of occupied FIFO entries.
- ovf_sticky  out  1  a saturation has occurred since the last clear.
- drop_sticky  out  1  a sample was discarded because the FIFO was full.
- clr_flags  in  1  synchronous clear of both sticky flags.

## Operation
- **Stage 1, round:** compute r = (sign-extend in_data to IN_W+1) + 2^(SHIFT-1), then arithmetic-shift r right by SHIFT. This is round-half-up. Register r together with the input valid bit.
- **Stage 2, saturate and decimate:**
  - Results above 2^(OUT_W-1)-1 clamp to 0x7FFF; results below -2^(OUT_W-1) clamp to 0x8000.
  - A clamp on a valid sample sets ovf_sticky.
  - Decimation counter dcnt runs 0..DECIM-1 and advances once per valid stage-2 sample.
  - A sample is kept only when dcnt==0, so the first sample after reset is kept.
  - Kept sample and keep strobe are registered.
- **FIFO write:** a kept sample is written if level<DEPTH, or if a read occurs in the same cycle.
  - Otherwise the sample is discarded, drop_sticky is set, and the level is unchanged.
- **FIFO read:** occurs when out_valid && out_ready. out_valid = (level!=0).
  - out_data is always the head entry (fall-through), so no extra read latency.
- **Simultaneous read and write:** level is unchanged. When empty, no read can occur and the write proceeds.
- **Pointers:** read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- **Sticky flags:** clr_flags clears both flags. If a set event and clr_flags occur in the same cycle, set wins.
- **Pipeline holding:** the pipeline never stalls. Stages 1 and 2 advance every cycle regardless of out_ready.

## Timing
- **Reset values:** out_valid=0, out_data=0, fifo_level=0, ovf_sticky=0, drop_sticky=0, dcnt=0, all pipeline valids 0.
- **Reset mid-operation:** in-flight and buffered samples are flushed, and reset asynchronously forces all reset values above.
- **Latency:** in_valid sampled at edge k; if kept and the FIFO is not full, it is written at edge k+2 and out_valid/out_data are visible from edge k+2.
- **Throughput:** one input per clock; one output per clock when out_ready is held high.
- **Flag timing:** ovf_sticky rises at edge k+1 after the stage-1 result is evaluated in stage 2. drop_sticky rises at the edge where the write is refused.
- **Idle input:** in_valid=0 cycles do not advance dcnt and produce no writes.

## Test plan
- **Rounding (DECIM=1, SHIFT=15, out_ready=1):**
  - in_data 0x00004000 → 0x0001
  - 0x00003FFF → 0x0000
  - 0xFFFFC000 → 0x0000
  - 0xFFFFBFFF → 0xFFFF
  - Each appears 2 cycles after input; ovf_sticky stays 0.
- **Saturation:**
  - 0x7FFFFFFF → 0x7FFF; 0x80000000 → 0x8000; ovf_sticky=1 from the following edge.
  - clr_flags pulse → 0. clr_flags asserted together with another clamp → stays 1.
- **Decimation (DECIM=2):** continuous inputs i<<15 for i=1..8 → outputs 1,3,5,7 in order; fifo_level never exceeds 1.
- **Backpressure/full (DECIM=2, DEPTH=4, out_ready=0):**
  - 12 inputs → 6 kept; 4 stored (values of inputs 1,3,5,7); fifo_level=4.
  - drop_sticky=1 after the 5th kept sample.
  - Then out_ready=1 → 1,3,5,7 drain on consecutive cycles; out_valid falls after the 4th.
- **Simultaneous read/write at full:**
  - FIFO at level 4 with out_ready=1 while a kept sample arrives → level stays 4, no drop, order preserved.
  - Pointer wrap verified over ≥3×DEPTH samples.
- **Reset mid-stream:**
  - Assert reset with level=3 and samples in the pipeline → out_valid=0 and level=0 immediately (asynchronously), flags cleared.
  - Next input after release is kept (dcnt=0).
